alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
//  Holds dispatched integer/branch ops until both operands are available, then issues one op per cycle to Alu.
//  Sits between decoder/ROB dispatch and Alu; snoops the common data bus (CDB) to capture pending operands.
//  Issue outputs are registered and map 1:1 onto Alu inputs (have_ins, ins_id, rs1_val ... request_PC).
// PARAMETERS
//  RS_DEPTH   4   number of entries (power of 2, 2..16)
//  TAG_W      3   ROB tag width; equals Alu ins_id width
// PORTS
//  clk_in          in   1      clock; all state updates on rising edge
//  rst_n_in        in   1      reset, asynchronous, active-low
//  rdy_in          in   1      global ready; low = freeze all state, have_ins forced 0
//  flush_pipline   in   1      mispredict flush; empties station
//  disp_valid      in   1      dispatch request this cycle
//  disp_tag        in   TAG_W  ROB tag of dispatched op
//  disp_opcode     in   7      opcode
//  disp_funct3     in   3      funct3
//  disp_funct7     in   7      funct7
//  disp_imm        in   32     immediate
//  disp_shamt      in   6      shift amount
//  disp_pc         in   32     instruction PC
//  disp_rs1_busy   in   1      1 = rs1 pending, wait on disp_rs1_tag
//  disp_rs1_tag    in   TAG_W  producer tag of rs1
//  disp_rs1_val    in   32     rs1 value when not busy
//  disp_rs2_busy/disp_rs2_tag/disp_rs2_val  same for rs2
//  cdb_valid       in   1      result broadcast valid
//  cdb_tag         in   TAG_W  producing tag
//  cdb_val         in   32     produced value
//  rs_full         out  1      combinational: all entries valid
//  have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val, opcode, funct3, funct7, request_PC
//                  out  (1,TAG_W,32,32,32,6,7,3,7,32)  registered issue bundle to Alu
// BEHAVIOUR
//  Reset (async, rst_n_in=0): all entry valid bits 0, have_ins 0, all other outputs 0; rs_full 0.
//  Per-entry state: EMPTY -> WAITING (operand busy) -> READY (both captured) -> EMPTY on issue; flush -> EMPTY.
//  Dispatch: accepted iff disp_valid & !rs_full & rdy_in & !flush; written to lowest-index EMPTY entry.
//   rs_full uses current-cycle occupancy; a same-cycle issue does NOT free a slot for a same-cycle dispatch.
//   disp_valid while rs_full: dropped (protocol violation; bench asserts it never happens).
//  Wakeup: every WAITING operand with busy & tag==cdb_tag & cdb_valid latches cdb_val, clears busy.
//   Dispatch-cycle bypass: if disp_rsX_busy and disp_rsX_tag==cdb_tag & cdb_valid, entry is written ready with cdb_val.
//  Issue select: lowest-index entry with valid & both operands ready, evaluated on pre-edge state.
//   Selected entry is cleared and its fields loaded into issue regs at the edge; have_ins=1 for exactly one cycle.
//   No ready entry -> have_ins 0; other issue outputs hold last value.
//  Latency: dispatch with ready operands at edge N -> have_ins high after edge N+1 (one cycle in station min).
//   CDB wakeup at edge N -> entry eligible for selection in cycle after N, issued at edge N+1.
//  rdy_in=0: no dispatch, wakeup, or issue; entries held; have_ins 0 after next edge.
//  flush_pipline=1 (priority over dispatch/issue/wakeup): all entries EMPTY, have_ins 0 at next edge.
//  Tag compare is exact TAG_W bits; tags wrap with ROB, station never compares age.
//  Selection is fixed-priority; starvation bounded by ROB commit stalling dispatch.
// CONFIGURATION
//  ALU_BYPASS_EN defined: second wakeup port alu_fwd_valid/alu_fwd_tag/alu_fwd_val (Alu alu_rdy/res_ins_id/alu_res)
//   handled identically to CDB (incl. dispatch bypass); if both match one operand, CDB wins.
//  Undefined: ports absent; operands wake on CDB only.
// STRUCTURE
//  Shared header rv32_defs.vh: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_REG), TAG_W default.
//  Sub-module rs_priority_pick: RS_DEPTH-bit request vector -> one-hot grant + found flag; used for free-slot and issue select.
// TESTING
//  Dispatch ADDI tag 2, rs1 ready 5, imm 7 -> have_ins 1 two edges later, ins_id 2, rs1_val 5, imm_val 7.
//  Dispatch ADD tag 1 rs1 busy on tag 4; cdb tag 4 val 0x10 3 cycles later -> issue next cycle, rs1_val 0x10.
//  Dispatch busy on tag 3 in same cycle cdb broadcasts tag 3 val 9 -> entry ready, issued with rs1_val 9.
//  Fill 4 ready-blocked entries -> rs_full 1; wakeup entry 2 -> entry 2 issues, rs_full 0 next cycle.
//  Flush with 3 valid entries and issue pending -> have_ins 0 next cycle, rs_full 0, no later issue.
//  rdy_in low 2 cycles with ready entry -> no issue while low; issued first cycle after rdy_in returns.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Provides widths, RV32 opcode constants and the packed op payload carried per entry.
package alu_reservation_station_pkg;

    localparam int unsigned RS_DEPTH_DEF = 4;
    localparam int unsigned TAG_W_DEF    = 3;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned OPC_W        = 7;
    localparam int unsigned F3_W         = 3;
    localparam int unsigned F7_W         = 7;
    localparam int unsigned SHAMT_W      = 6;

    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

    // Operand-independent fields of a dispatched op, passed through to the Alu untouched.
    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [F3_W-1:0]    funct3;
        logic [F7_W-1:0]    funct7;
        logic [XLEN-1:0]    imm;
        logic [SHAMT_W-1:0] shamt;
        logic [XLEN-1:0]    pc;
    } op_payload_t;

endpackage

// File: rtl/alu_reservation_station_pick.sv
// rs_priority_pick: fixed-priority arbiter, lowest index wins.
// Ports: req_i (request vector), gnt_o (one-hot grant), found_o (any request set).
module rs_priority_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         found_o
);

    always_comb begin
        gnt_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req_i[i] && !found_o) begin
                gnt_o[i] = 1'b1;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: holds dispatched integer/branch ops until both operands are
// captured (at dispatch or by snooping the CDB), then issues one op per cycle to the Alu.
// Ports: clk_in/rst_n_in (async active-low), rdy_in (global stall), flush_pipline,
//   disp_* (dispatch request), cdb_* (result broadcast), rs_full (combinational),
//   have_ins .. request_PC (registered issue bundle to the Alu).
// Build option: define ALU_BYPASS_EN to add a second wakeup port alu_fwd_* (CDB has priority).
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int unsigned RS_DEPTH = RS_DEPTH_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_pipline,
    input  logic                disp_valid,
    input  logic [TAG_W-1:0]    disp_tag,
    input  logic [OPC_W-1:0]    disp_opcode,
    input  logic [F3_W-1:0]     disp_funct3,
    input  logic [F7_W-1:0]     disp_funct7,
    input  logic [XLEN-1:0]     disp_imm,
    input  logic [SHAMT_W-1:0]  disp_shamt,
    input  logic [XLEN-1:0]     disp_pc,
    input  logic                disp_rs1_busy,
    input  logic [TAG_W-1:0]    disp_rs1_tag,
    input  logic [XLEN-1:0]     disp_rs1_val,
    input  logic                disp_rs2_busy,
    input  logic [TAG_W-1:0]    disp_rs2_tag,
    input  logic [XLEN-1:0]     disp_rs2_val,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [XLEN-1:0]     cdb_val,
`ifdef ALU_BYPASS_EN
    input  logic                alu_fwd_valid,
    input  logic [TAG_W-1:0]    alu_fwd_tag,
    input  logic [XLEN-1:0]     alu_fwd_val,
`endif
    output logic                rs_full,
    output logic                have_ins,
    output logic [TAG_W-1:0]    ins_id,
    output logic [XLEN-1:0]     rs1_val,
    output logic [XLEN-1:0]     rs2_val,
    output logic [XLEN-1:0]     imm_val,
    output logic [SHAMT_W-1:0]  shamt_val,
    output logic [OPC_W-1:0]    opcode,
    output logic [F3_W-1:0]     funct3,
    output logic [F7_W-1:0]     funct7,
    output logic [XLEN-1:0]     request_PC
);

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    // Entry storage; an entry is EMPTY (!valid), WAITING (a busy bit set) or READY.
    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [RS_DEPTH-1:0] b1_q, b1_d, b2_q, b2_d;
    logic [TAG_W-1:0]    tag_q [RS_DEPTH];
    logic [TAG_W-1:0]    tag_d [RS_DEPTH];
    logic [TAG_W-1:0]    t1_q  [RS_DEPTH];
    logic [TAG_W-1:0]    t1_d  [RS_DEPTH];
    logic [TAG_W-1:0]    t2_q  [RS_DEPTH];
    logic [TAG_W-1:0]    t2_d  [RS_DEPTH];
    logic [XLEN-1:0]     v1_q  [RS_DEPTH];
    logic [XLEN-1:0]     v1_d  [RS_DEPTH];
    logic [XLEN-1:0]     v2_q  [RS_DEPTH];
    logic [XLEN-1:0]     v2_d  [RS_DEPTH];
    op_payload_t         pay_q [RS_DEPTH];
    op_payload_t         pay_d [RS_DEPTH];

    // Issue bundle registers.
    logic                have_ins_q, have_ins_d;
    logic [TAG_W-1:0]    ins_id_q, ins_id_d;
    logic [XLEN-1:0]     rs1_q, rs1_d, rs2_q, rs2_d;
    op_payload_t         iss_pay_q, iss_pay_d;

    logic [RS_DEPTH-1:0] free_gnt, iss_gnt;
    logic                free_found, iss_found;
    logic [IDX_W-1:0]    free_idx, iss_idx;

    assign rs_full = &valid_q;

    rs_priority_pick #(.N(RS_DEPTH)) u_free_pick (
        .req_i   (~valid_q),
        .gnt_o   (free_gnt),
        .found_o (free_found)
    );

    rs_priority_pick #(.N(RS_DEPTH)) u_issue_pick (
        .req_i   (valid_q & ~b1_q & ~b2_q),
        .gnt_o   (iss_gnt),
        .found_o (iss_found)
    );

    // One-hot grants to indices.
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            if (free_gnt[i]) free_idx = IDX_W'(i);
            if (iss_gnt[i])  iss_idx  = IDX_W'(i);
        end
    end

    // Operand capture: returns {busy, value} after snooping the broadcast ports.
    function automatic logic [XLEN:0] wake(input logic busy, input logic [TAG_W-1:0] tag,
                                           input logic [XLEN-1:0] val);
        wake = {busy, val};
        if (busy && cdb_valid && (tag == cdb_tag)) begin
            wake = {1'b0, cdb_val};
        end
`ifdef ALU_BYPASS_EN
        else if (busy && alu_fwd_valid && (tag == alu_fwd_tag)) begin
            wake = {1'b0, alu_fwd_val};
        end
`endif
    endfunction

    // Next-state: stall holds everything, flush empties, otherwise wakeup + issue + dispatch.
    always_comb begin
        valid_d    = valid_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        tag_d      = tag_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        pay_d      = pay_q;
        have_ins_d = 1'b0;
        ins_id_d   = ins_id_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        iss_pay_d  = iss_pay_q;

        if (!rdy_in) begin
            have_ins_d = 1'b0;
        end else if (flush_pipline) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                {b1_d[i], v1_d[i]} = wake(b1_q[i], t1_q[i], v1_q[i]);
                {b2_d[i], v2_d[i]} = wake(b2_q[i], t2_q[i], v2_q[i]);
            end
            if (iss_found) begin
                valid_d[iss_idx] = 1'b0;
                have_ins_d       = 1'b1;
                ins_id_d         = tag_q[iss_idx];
                rs1_d            = v1_q[iss_idx];
                rs2_d            = v2_q[iss_idx];
                iss_pay_d        = pay_q[iss_idx];
            end
            // free_found is exactly !rs_full on current occupancy; an issuing slot is not reused.
            if (disp_valid && free_found) begin
                valid_d[free_idx] = 1'b1;
                tag_d[free_idx]   = disp_tag;
                t1_d[free_idx]    = disp_rs1_tag;
                t2_d[free_idx]    = disp_rs2_tag;
                {b1_d[free_idx], v1_d[free_idx]} = wake(disp_rs1_busy, disp_rs1_tag, disp_rs1_val);
                {b2_d[free_idx], v2_d[free_idx]} = wake(disp_rs2_busy, disp_rs2_tag, disp_rs2_val);
                pay_d[free_idx]   = '{opcode: disp_opcode, funct3: disp_funct3, funct7: disp_funct7,
                                      imm: disp_imm, shamt: disp_shamt, pc: disp_pc};
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q    <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                tag_q[i] <= '0;
                t1_q[i]  <= '0;
                t2_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                pay_q[i] <= '0;
            end
            have_ins_q <= 1'b0;
            ins_id_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            iss_pay_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            tag_q      <= tag_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            pay_q      <= pay_d;
            have_ins_q <= have_ins_d;
            ins_id_q   <= ins_id_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            iss_pay_q  <= iss_pay_d;
        end
    end

    assign have_ins   = have_ins_q;
    assign ins_id     = ins_id_q;
    assign rs1_val    = rs1_q;
    assign rs2_val    = rs2_q;
    assign imm_val    = iss_pay_q.imm;
    assign shamt_val  = iss_pay_q.shamt;
    assign opcode     = iss_pay_q.opcode;
    assign funct3     = iss_pay_q.funct3;
    assign funct7     = iss_pay_q.funct7;
    assign request_PC = iss_pay_q.pc;

endmodule
